// File: rtl/tuser_pkg.sv
// tuser_pkg: shared defaults, SOP FSM state encoding and clog2 helper
package tuser_pkg;

    localparam int TUSER_W_DEFAULT = 128;

    typedef enum logic {
        ST_SOP_WAIT = 1'b0,
        ST_IN_PKT   = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/tuple_fifo.sv
// tuple_fifo: registered first-word-fall-through FIFO, accepts push+pop in one cycle even when full
// Ports: clk/rst_n (async active-low), push/din write side, pop/dout read side,
//        full/empty/count status (count never exceeds DEPTH)
module tuple_fifo
    import tuser_pkg::*;
#(
    parameter int WIDTH = TUSER_W_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW + 1)'(DEPTH));
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop & ~empty;
    // a pop in the same cycle frees the slot the push needs
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tuser_in_fsm.sv
// tuser_in_fsm: captures AXIS tuser on each packet's SOP beat and queues it as the SDNet input tuple
// Ports: tin_aclk/tin_arst (async active-low) clock and reset;
//        tin_avalid/tin_aready/tin_tlast/tin_atuser monitored AXIS stream;
//        tin_tready/tin_valid/tin_data tuple handshake;
//        tin_hold queue-full back-pressure, tin_drop lost-SOP pulse, tin_drop_cnt saturating drop count
module tuser_in_fsm
    import tuser_pkg::*;
#(
    parameter int TUSER_W    = TUSER_W_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic               tin_aclk,
    input  logic               tin_arst,
    input  logic               tin_avalid,
    input  logic               tin_aready,
    input  logic               tin_tlast,
    input  logic [TUSER_W-1:0] tin_atuser,
    input  logic               tin_tready,
    output logic               tin_valid,
    output logic [TUSER_W-1:0] tin_data,
    output logic               tin_hold,
    output logic               tin_drop,
    output logic [CNT_W-1:0]   tin_drop_cnt
);

    localparam int AW = clog2(FIFO_DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [AW:0]      fifo_count;
    logic             fifo_empty, beat, sop, pop, accept;

    assign beat     = tin_avalid & tin_aready;
    assign sop      = beat & (state_q == ST_SOP_WAIT);
    assign pop      = tin_valid & tin_tready;
    assign accept   = (fifo_count < (AW + 1)'(FIFO_DEPTH)) | pop;
    assign tin_drop = sop & ~accept;
    assign tin_valid    = ~fifo_empty;
    assign tin_drop_cnt = drop_cnt_q;

    // every beat ends in SOP_WAIT on tlast and in IN_PKT otherwise, whatever the current state
    always_comb begin
        state_d    = beat ? (tin_tlast ? ST_SOP_WAIT : ST_IN_PKT) : state_q;
        drop_cnt_d = (tin_drop && drop_cnt_q != '1) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    end

    always_ff @(posedge tin_aclk or negedge tin_arst) begin
        if (!tin_arst) begin
            state_q    <= ST_SOP_WAIT;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    tuple_fifo #(
        .WIDTH (TUSER_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (tin_aclk),
        .rst_n (tin_arst),
        .push  (sop),
        .din   (tin_atuser),
        .pop   (pop),
        .dout  (tin_data),
        .full  (tin_hold),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_tuser_in_fsm.sv
// tb_tuser_in_fsm: directed and random stimulus checked against a queue-based packet model
module tb_tuser_in_fsm;

    localparam int W  = 128;
    localparam int D  = 4;
    localparam int CW = 16;

    logic          clk = 0, arst_n = 0, av = 0, ar = 0, last = 0, tr = 0;
    logic [W-1:0]  tu = '0;
    logic          tin_valid, tin_hold, tin_drop;
    logic [W-1:0]  tin_data;
    logic [CW-1:0] tin_drop_cnt;

    int n_chk = 0, n_fail = 0;

    logic [W-1:0] q[$];
    bit           in_pkt = 0;
    int unsigned  drops = 0;

    tuser_in_fsm #(.TUSER_W(W), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
        .tin_aclk     (clk),
        .tin_arst     (arst_n),
        .tin_avalid   (av),
        .tin_aready   (ar),
        .tin_tlast    (last),
        .tin_atuser   (tu),
        .tin_tready   (tr),
        .tin_valid    (tin_valid),
        .tin_data     (tin_data),
        .tin_hold     (tin_hold),
        .tin_drop     (tin_drop),
        .tin_drop_cnt (tin_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_pop();
        return q.size() != 0 && tr;
    endfunction

    function automatic bit m_sop();
        return av && ar && !in_pkt;
    endfunction

    function automatic bit m_acc();
        return q.size() < D || m_pop();
    endfunction

    task automatic model_check();
        chkb("valid", tin_valid, q.size() != 0);
        if (q.size() != 0) chkw("data", tin_data, q[0]);
        chkb("hold", tin_hold, q.size() == D);
        chkb("drop", tin_drop, m_sop() && !m_acc());
        chkw("drop_cnt", W'(tin_drop_cnt), W'(drops));
    endtask

    task automatic cycle();
        bit pop, push, drop, nxt;
        logic [W-1:0] v;
        @(negedge clk);
        model_check();
        pop  = m_pop();
        push = m_sop() && m_acc();
        drop = m_sop() && !m_acc();
        nxt  = (av && ar) ? !last : in_pkt;
        v    = tu;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(v);
        if (drop && drops < 65535) drops++;
        in_pkt = nxt;
        #1;
    endtask

    task automatic drive(input logic a_v, input logic a_r, input logic l, input logic [W-1:0] u, input logic t);
        av = a_v; ar = a_r; last = l; tu = u; tr = t;
    endtask

    task automatic step(input logic a_v, input logic a_r, input logic l, input logic [W-1:0] u, input logic t);
        drive(a_v, a_r, l, u, t);
        cycle();
    endtask

    initial begin
        logic [3:0]   nib;
        logic [W-1:0] val;
        @(posedge clk);
        #1;
        chkb("rst_valid", tin_valid, 1'b0);
        chkw("rst_data", tin_data, '0);
        chkb("rst_hold", tin_hold, 1'b0);
        chkb("rst_drop", tin_drop, 1'b0);
        chkw("rst_cnt", W'(tin_drop_cnt), '0);
        @(posedge clk);
        #1 arst_n = 1;

        // three 4-beat packets, garbage tuser after SOP
        for (int i = 0; i < 3; i++) begin
            nib = 4'hA + 4'(i);
            val = {32{nib}};
            step(1, 1, 0, val, 1);
            chkb("t1_valid", tin_valid, 1'b1);
            chkw("t1_data", tin_data, val);
            step(1, 1, 0, {4{32'hDEAD_BEEF}}, 1);
            chkb("t1_gone", tin_valid, 1'b0);
            step(1, 1, 0, {4{32'hDEAD_BEEF}}, 1);
            step(1, 1, 1, {4{32'hDEAD_BEEF}}, 1);
        end

        // back-to-back single-beat packets
        for (int i = 1; i <= 6; i++) begin
            step(1, 1, 1, W'(i), 1);
            chkw("t2_data", tin_data, W'(i));
        end
        step(0, 0, 0, '0, 1);

        // fill with consumer stalled, fifth SOP dropped
        for (int i = 1; i <= 4; i++) step(1, 1, 1, W'(i), 0);
        chkb("t3_hold", tin_hold, 1'b1);
        drive(1, 1, 1, W'(5), 0);
        #1 chkb("t3_drop", tin_drop, 1'b1);
        cycle();
        chkw("t3_cnt", W'(tin_drop_cnt), W'(1));
        drive(0, 0, 0, '0, 1);
        for (int i = 1; i <= 4; i++) begin
            chkw("t3_drain", tin_data, W'(i));
            cycle();
        end
        chkb("t3_empty", tin_valid, 1'b0);

        // full queue with simultaneous pop and SOP
        for (int i = 11; i <= 14; i++) step(1, 1, 1, W'(i), 0);
        drive(1, 1, 1, W'(15), 1);
        #1 chkb("t4_nodrop", tin_drop, 1'b0);
        cycle();
        chkb("t4_hold", tin_hold, 1'b1);
        chkw("t4_cnt", W'(tin_drop_cnt), W'(1));
        drive(0, 0, 0, '0, 1);
        for (int i = 12; i <= 15; i++) begin
            chkw("t4_drain", tin_data, W'(i));
            cycle();
        end

        // valid without ready stalls the FSM
        drive(1, 0, 0, W'('h77), 0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chkb("t5_stall", tin_valid, 1'b0);
        end
        step(1, 1, 1, W'('h55), 0);
        chkb("t5_valid", tin_valid, 1'b1);
        chkw("t5_data", tin_data, W'('h55));
        step(0, 0, 0, '0, 1);

        // async reset mid-packet with two entries queued
        step(1, 1, 1, W'('h20), 0);
        step(1, 1, 0, W'('h21), 0);
        #2 arst_n = 0;
        #1;
        chkb("t6_valid", tin_valid, 1'b0);
        chkb("t6_hold", tin_hold, 1'b0);
        chkw("t6_cnt", W'(tin_drop_cnt), '0);
        q.delete();
        in_pkt = 0;
        drops  = 0;
        @(posedge clk);
        #2 arst_n = 1;
        step(1, 1, 0, W'('h99), 0);
        chkb("t6_sop_valid", tin_valid, 1'b1);
        chkw("t6_sop_data", tin_data, W'('h99));
        step(1, 1, 1, W'('hBAD), 0);
        chkw("t6_ignore", tin_data, W'('h99));
        step(0, 0, 0, '0, 1);

        // random traffic
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 9) < 4), {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 2) != 0));
        for (int i = 0; i < 6; i++) step(0, 0, 0, '0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
